// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with a one-entry skid buffer behind the head entry.
// Latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1.
// Backpressure: in_ready drops once the skid slot is occupied or the stage has halted.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_val,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic              in_hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_val,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic              out_hlt,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              halted,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_val;
        logic [REG_W-1:0]  rd;
        logic              mem_to_reg;
        logic              reg_write;
        logic              hlt;
    } entry_t;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_vld_q, head_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   halted_q, halted_d;

    entry_t in_e;
    logic   accept;
    logic   pop;

    assign in_e = '{mem_data:   in_mem_data,
                    alu_val:    in_alu_val,
                    rd:         in_rd,
                    mem_to_reg: in_mem_to_reg,
                    reg_write:  in_reg_write,
                    hlt:        in_hlt};

    // Ready depends only on registered state so upstream never sees a path from out_ready.
    assign in_ready = !skid_vld_q && !halted_q;
    assign accept   = in_valid && in_ready;
    assign pop      = head_vld_q && out_ready;

    // Next-state selection; flush wins over every load, but a popped hlt still latches halted.
    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        halted_d   = halted_q;

        if (pop && head_q.hlt) begin
            halted_d = 1'b1;
        end

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop && skid_vld_q) begin
            // skid full implies in_ready=0, so no accept can collide here
            head_d     = skid_q;
            skid_vld_d = 1'b0;
        end else if (accept && (!head_vld_q || pop)) begin
            head_d     = in_e;
            head_vld_d = 1'b1;
        end else if (accept) begin
            skid_d     = in_e;
            skid_vld_d = 1'b1;
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
    end

    // State registers; reset overrides everything, including a pending pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            halted_q   <= halted_d;
        end
    end

    // Control bits are masked when the head is empty so writeback never sees a stale write.
    assign out_valid      = head_vld_q;
    assign out_mem_data   = head_q.mem_data;
    assign out_alu_val    = head_q.alu_val;
    assign out_rd         = head_q.rd;
    assign out_mem_to_reg = head_vld_q && head_q.mem_to_reg;
    assign out_reg_write  = head_vld_q && head_q.reg_write;
    assign out_hlt        = head_vld_q && head_q.hlt;
    assign out_wb_data    = head_q.mem_to_reg ? head_q.mem_data : head_q.alu_val;
    assign halted         = halted_q;
    assign occupancy      = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by random traffic.
// Reference model is an in-order queue of at most two entries plus a halted flag.
// Inputs driven on the falling edge; outputs compared before each rising edge.
module tb_mem_wb_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_alu_val;
    logic [REG_W-1:0]  in_rd;
    logic              in_mem_to_reg;
    logic              in_reg_write;
    logic              in_hlt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_alu_val;
    logic [REG_W-1:0]  out_rd;
    logic              out_mem_to_reg;
    logic              out_reg_write;
    logic              out_hlt;
    logic [DATA_W-1:0] out_wb_data;
    logic              halted;
    logic [1:0]        occupancy;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_data    (in_mem_data),
        .in_alu_val     (in_alu_val),
        .in_rd          (in_rd),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .in_hlt         (in_hlt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_data   (out_mem_data),
        .out_alu_val    (out_alu_val),
        .out_rd         (out_rd),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .out_hlt        (out_hlt),
        .out_wb_data    (out_wb_data),
        .halted         (halted),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_val;
        logic [REG_W-1:0]  rd;
        logic              mem_to_reg;
        logic              reg_write;
        logic              hlt;
    } ent_t;

    ent_t mq[$];
    bit   m_halted;
    int   m_retired;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model's view of the stage.
    task automatic check_all();
        bit   ev;
        ent_t h;
        ev = (mq.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready",  32'(in_ready),  32'((mq.size() < 2) && !m_halted));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("halted",    32'(halted),    32'(m_halted));
        if (ev) begin
            h = mq[0];
            chk("out_rd",         32'(out_rd),         32'(h.rd));
            chk("out_mem_data",   32'(out_mem_data),   32'(h.mem_data));
            chk("out_alu_val",    32'(out_alu_val),    32'(h.alu_val));
            chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(h.mem_to_reg));
            chk("out_reg_write",  32'(out_reg_write),  32'(h.reg_write));
            chk("out_hlt",        32'(out_hlt),        32'(h.hlt));
            chk("out_wb_data",    32'(out_wb_data),
                32'(h.mem_to_reg ? h.mem_data : h.alu_val));
        end else begin
            chk("out_mem_to_reg_idle", 32'(out_mem_to_reg), 32'd0);
            chk("out_reg_write_idle",  32'(out_reg_write),  32'd0);
            chk("out_hlt_idle",        32'(out_hlt),        32'd0);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        bit   acc;
        ent_t e;
        ent_t n;
        if (rst) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < 2) && !m_halted;
            if (out_ready && mq.size() > 0) begin
                e = mq.pop_front();
                m_retired++;
                if (e.hlt) m_halted = 1'b1;
            end
            if (flush) begin
                mq.delete();
            end else if (acc) begin
                n.mem_data   = in_mem_data;
                n.alu_val    = in_alu_val;
                n.rd         = in_rd;
                n.mem_to_reg = in_mem_to_reg;
                n.reg_write  = in_reg_write;
                n.hlt        = in_hlt;
                mq.push_back(n);
            end
        end
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] md,
                         input logic [DATA_W-1:0] av, input logic m2r, input logic rw, input logic h);
        in_valid      = v;
        in_rd         = rd;
        in_mem_data   = md;
        in_alu_val    = av;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_hlt        = h;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_mem_data"}, 32'(out_mem_data), 32'd0);
        chk({tag, "_alu_val"},  32'(out_alu_val),  32'd0);
        chk({tag, "_rd"},       32'(out_rd),       32'd0);
        chk({tag, "_wb_data"},  32'(out_wb_data),  32'd0);
        chk({tag, "_valid"},    32'(out_valid),    32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),     32'd1);
    endtask

    initial begin
        int ret_before;
        checks = 0; errors = 0; m_retired = 0; m_halted = 1'b0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_halted",    32'(halted),    32'd0);

        // Streaming: one entry appears the next cycle
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("stream_rd",   32'(out_rd),      32'd3);
        chk("stream_wb",   32'(out_wb_data), 32'h1234);
        chk("stream_occ",  32'(occupancy),   32'd1);
        tick();

        // Backpressure: two entries held, drained in order
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 16'h0A0A, 16'h0555, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd6, 16'h0B0B, 16'h0666, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd7, 16'h0C0C, 16'h0777, 1'b0, 1'b1, 1'b0);
        chk("bp_occ",      32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        tick();
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_first_rd", 32'(out_rd), 32'd5);
        tick();
        chk("bp_second_rd",    32'(out_rd),   32'd6);
        chk("bp_ready_after",  32'(in_ready), 32'd1);
        tick();
        tick();

        // mem_to_reg selects the writeback source
        drive(1'b1, 4'd1, 16'hBEEF, 16'h0001, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd2, 16'hBEEF, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("m2r_mem", 32'(out_wb_data), 32'hBEEF);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("m2r_alu", 32'(out_wb_data), 32'h0001);
        tick();

        // Flush with two held entries and a new one offered
        out_ready = 1'b0;
        drive(1'b1, 4'd8, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd9, 16'h3333, 16'h4444, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd10, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_occ",   32'(occupancy),     32'd0);
        chk("flush_valid", 32'(out_valid),     32'd0);
        chk("flush_rw",    32'(out_reg_write), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_gone",  32'(out_valid), 32'd0);

        // Halt: stage stops accepting until reset
        drive(1'b1, 4'd4, 16'h0, 16'h00FF, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'd11, 16'h0, 16'h0ABC, 1'b0, 1'b1, 1'b0);
        tick();
        chk("halt_set",      32'(halted),    32'd1);
        chk("halt_in_ready", 32'(in_ready),  32'd0);
        repeat (3) tick();
        chk("halt_held",     32'(halted),    32'd1);
        chk("halt_no_accept",32'(occupancy), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("halt_cleared",  32'(halted),   32'd0);
        chk("halt_ready",    32'(in_ready), 32'd1);

        // Reset mid-backpressure with a pop requested
        out_ready = 1'b0;
        drive(1'b1, 4'd12, 16'h7777, 16'h8888, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd13, 16'h9999, 16'hAAAA, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rstmid_occ2", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        rst = 1'b1;
        ret_before = m_retired;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rstmid_occ",     32'(occupancy),     32'd0);
        chk("rstmid_rw",      32'(out_reg_write), 32'd0);
        chk("rstmid_m2r",     32'(out_mem_to_reg),32'd0);
        chk("rstmid_retired", 32'(m_retired),     32'(ret_before));
        check_zero_outputs("rstmid");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 24) == 0);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            rst       = $urandom_range(0, 39) == 0;
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of memory-read and ALU-result fields.
REQ-002 SHALL have parameter REG_W, default 4, width of destination-register field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all held and incoming entries.
REQ-006 SHALL have port in_valid  input  1  upstream (MEM) entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-008 SHALL have port in_mem_data, in_alu_val  input  DATA_W each  memory-read data, ALU/mux result.
REQ-009 SHALL have port in_rd  input  REG_W  destination register.
REQ-010 SHALL have port in_mem_to_reg, in_reg_write, in_hlt  input  1 each  control bits.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  writeback consumes head entry.
REQ-013 SHALL have port out_mem_data, out_alu_val  output  DATA_W; out_rd  output  REG_W; out_mem_to_reg, out_reg_write, out_hlt  output  1; head-entry fields.
REQ-014 SHALL have port out_wb_data  output  DATA_W  out_mem_to_reg ? out_mem_data : out_alu_val.
REQ-015 SHALL have port halted  output  1  sticky, set after a hlt entry retires.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-017 SHALL hold up to two entries: head (drives outputs) and skid (behind head); fully registered, no combinational in->out path.
REQ-018 SHALL drive in_ready = (skid empty) AND NOT halted, from registered state only (no dependence on out_ready).
REQ-019 Accept = in_valid AND in_ready; pop = out_valid AND out_ready.
REQ-020 Latency: entry accepted into empty stage in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-021 Accept, head empty: entry loads head.
REQ-022 Accept, head full, no pop: entry loads skid.
REQ-023 Accept with pop, skid empty: entry loads head (occupancy stays 1).
REQ-024 Pop with skid full: skid moves to head, skid empties; in_ready=1 next cycle (accept impossible same cycle since in_ready=0).
REQ-025 Entries SHALL retire in acceptance order; none dropped or duplicated except by flush/reset.
REQ-026 occupancy SHALL equal number of held entries, never exceed 2.
REQ-027 out_valid=0: out_reg_write, out_mem_to_reg, out_hlt SHALL read 0; data fields hold last value (don't-care).
REQ-028 flush=1: both entries SHALL be invalidated next cycle; entry accepted same cycle discarded; a pop same cycle still retires (halt update per REQ-029 applies); flush has priority over loads.
REQ-029 Pop of entry with hlt=1 SHALL set halted next cycle; halted then holds until rst; no accepts while halted; already-held skid entry still drains.
REQ-030 out_wb_data SHALL be combinational from head registers only.

Reset
REQ-031 rst=1 at a rising edge SHALL clear both entries, halted, occupancy; all out_* data/control fields 0; in_ready=1 next cycle.
REQ-032 rst SHALL take priority over flush, accept, pop, and halt update, including mid-backpressure with 2 entries held.

Verification
REQ-033 Stream: out_ready=1, accept A(rd=3,val=0x1234,reg_write=1) cycle 0 -> cycle 1 out_valid=1, out_rd=3, out_wb_data=0x1234; occupancy=1.
REQ-034 Backpressure: out_ready=0, send A,B -> occupancy=2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 one cycle after A pops.
REQ-035 mem_to_reg: entry mem_data=0xBEEF, alu_val=0x0001, mem_to_reg=1 -> out_wb_data=0xBEEF; with mem_to_reg=0 -> 0x0001.
REQ-036 Flush: 2 entries held, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_reg_write=0; incoming entry never appears.
REQ-037 Halt: entry hlt=1 pops -> halted=1, in_ready=0 next cycle and stays; in_valid ignored until rst=1, then halted=0, in_ready=1.
REQ-038 Reset mid-op: rst=1 with occupancy=2 and out_ready=1 -> next cycle occupancy=0, all outputs 0, no entry retired that cycle.
